// File: rtl/hankel_matrix_writer.sv
// Takes a ROW x COL Hankel matrix in row-major order and writes its generating sequence to memory.
// Optional `HANKEL_CHECK_EN adds a sequence buffer and a sticky err flag for non-Hankel input.
module hankel_matrix_writer #(
  parameter int ROW   = 4,
  parameter int COL   = 4,
  parameter int WIDTH = 16,
  parameter int ADDR  = 8,
  parameter int BASE  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_in_ready,
  output logic [ADDR-1:0]  o_addr,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_wr,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int SEQ = ROW + COL - 1;
  localparam int RW  = $clog2(ROW);
  localparam int CW  = $clog2(COL);
  localparam int KW  = $clog2(SEQ);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic            r_wr;
  logic [ADDR-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic            w_accept, w_start_acc, w_last_col, w_last_row, w_new;
  logic [KW-1:0]   w_k;

  // An element opens a new sequence index only on row 0 or the last column.
  assign w_last_col = (r_col == CW'(COL - 1));
  assign w_last_row = (r_row == RW'(ROW - 1));
  assign w_new      = (r_row == '0) || w_last_col;
  assign w_k        = KW'(r_row) + KW'(r_col);
  assign w_accept   = o_in_ready & i_in_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_next      = S_RECV;
        end
      end
      S_RECV: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (i_in_valid && w_last_col && w_last_row) w_next = S_DONE;
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row   <= '0;
      r_col   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_wr <= w_accept & w_new;
      if (w_start_acc) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      // Address wraps modulo 2^ADDR by construction of the sum width.
      if (w_accept && w_new) begin
        r_addr  <= ADDR'(BASE) + ADDR'(w_k);
        r_wdata <= i_in_data;
      end
    end
  end

  assign o_wr    = r_wr;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

`ifdef HANKEL_CHECK_EN
  logic [WIDTH-1:0] r_seq [SEQ];
  logic             r_err;

  always_ff @(posedge i_clk) begin
    if (w_accept && w_new) r_seq[w_k] <= i_in_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)            r_err <= 1'b0;
    else if (w_start_acc) r_err <= 1'b0;
    else if (w_accept && !w_new && (i_in_data != r_seq[w_k])) r_err <= 1'b1;
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_hankel_matrix_writer.sv
// Directed bench: two 4x4 instances (BASE 0 and 250) share stimulus, a 2x3 instance is table-driven.
module tb_hankel_matrix_writer;

`ifdef HANKEL_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start4 = 1'b0, valid4 = 1'b0;
  logic [15:0] data4 = '0;
  logic        start2 = 1'b0, valid2 = 1'b0;
  logic [15:0] data2 = '0;

  logic        ready0, wr0, busy0, done0, err0;
  logic [7:0]  addr0;
  logic [15:0] wdata0;
  logic        ready1, wr1, busy1, done1, err1;
  logic [7:0]  addr1;
  logic [15:0] wdata1;
  logic        ready2, wr2, busy2, done2, err2;
  logic [7:0]  addr2;
  logic [15:0] wdata2;

  hankel_matrix_writer #(.ROW(4), .COL(4), .WIDTH(16), .ADDR(8), .BASE(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_in_valid(valid4), .i_in_data(data4),
    .o_in_ready(ready0), .o_addr(addr0), .o_wdata(wdata0), .o_wr(wr0),
    .o_busy(busy0), .o_done(done0), .o_err(err0));

  hankel_matrix_writer #(.ROW(4), .COL(4), .WIDTH(16), .ADDR(8), .BASE(250)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_in_valid(valid4), .i_in_data(data4),
    .o_in_ready(ready1), .o_addr(addr1), .o_wdata(wdata1), .o_wr(wr1),
    .o_busy(busy1), .o_done(done1), .o_err(err1));

  hankel_matrix_writer #(.ROW(2), .COL(3), .WIDTH(16), .ADDR(8), .BASE(0)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_in_valid(valid2), .i_in_data(data2),
    .o_in_ready(ready2), .o_addr(addr2), .o_wdata(wdata2), .o_wr(wr2),
    .o_busy(busy2), .o_done(done2), .o_err(err2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Write capture for the 4x4 instances.
  int qa0[$], qd0[$], qa1[$], qd1[$];
  int ndone0 = 0;
  always @(negedge clk) begin
    if (wr0) begin qa0.push_back(int'(addr0)); qd0.push_back(int'(wdata0)); end
    if (wr1) begin qa1.push_back(int'(addr1)); qd1.push_back(int'(wdata1)); end
    if (done0) ndone0++;
  end

  task automatic check_writes(input string tag, input int n);
    chk({tag, "_nwr0"}, qa0.size(), n);
    chk({tag, "_nwr1"}, qa1.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < qa0.size()) begin
        chk({tag, "_addr0"}, qa0[k], k);
        chk({tag, "_data0"}, qd0[k], k + 1);
      end
      if (k < qa1.size()) begin
        chk({tag, "_addr1"}, qa1[k], (250 + k) % 256);
        chk({tag, "_data1"}, qd1[k], k + 1);
      end
    end
    qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
  endtask

  // Element (r,c) = r+c+1; bad_idx replaces one element with 99.
  task automatic run4(input string tag, input bit gap, input int bad_idx);
    int exp_err;
    exp_err = (bad_idx >= 0) ? CHK : 0;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    chk({tag, "_ready_after_start"}, int'(ready0), 1);
    chk({tag, "_busy_after_start"}, int'(busy0), 1);
    chk({tag, "_err_cleared"}, int'(err0), 0);
    for (int idx = 0; idx < 16; idx++) begin
      if (gap && idx > 0) begin
        valid4 = 1'b0;
        @(negedge clk);
      end
      valid4 = 1'b1;
      data4  = (idx == bad_idx) ? 16'd99 : 16'((idx / 4) + (idx % 4) + 1);
      @(negedge clk);
      if (idx == bad_idx) chk({tag, "_err_after_bad"}, int'(err0), CHK);
    end
    valid4 = 1'b0;
    chk({tag, "_done"}, int'(done0), 1);
    chk({tag, "_final_wr"}, int'(wr0), 1);
    chk({tag, "_final_addr"}, int'(addr0), 6);
    chk({tag, "_final_addr1"}, int'(addr1), 0);
    chk({tag, "_ready_in_done"}, int'(ready0), 0);
    chk({tag, "_busy_in_done"}, int'(busy0), 1);
    chk({tag, "_err_at_done"}, int'(err0), exp_err);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done0), 0);
    chk({tag, "_busy_idle"}, int'(busy0), 0);
    chk({tag, "_wr_idle"}, int'(wr0), 0);
    check_writes(tag, 7);
  endtask

  typedef struct {
    bit st; bit vl; int d;
    int rdy; int wr; int a; int wd; int busy; int done;
  } vec_t;
  vec_t tv[11];

  initial begin
    // 2x3 matrix {10,11,12},{11,12,13} with one gap and ignored input afterwards.
    tv[0]  = '{1, 0,  0, 1, 0, 0,  0, 1, 0};
    tv[1]  = '{0, 1, 10, 1, 1, 0, 10, 1, 0};
    tv[2]  = '{0, 1, 11, 1, 1, 1, 11, 1, 0};
    tv[3]  = '{0, 1, 12, 1, 1, 2, 12, 1, 0};
    tv[4]  = '{0, 0,  0, 1, 0, 2, 12, 1, 0};
    tv[5]  = '{1, 1, 11, 1, 0, 2, 12, 1, 0};
    tv[6]  = '{0, 1, 12, 1, 0, 2, 12, 1, 0};
    tv[7]  = '{0, 1, 13, 0, 1, 3, 13, 1, 1};
    tv[8]  = '{0, 1, 55, 0, 0, 3, 13, 0, 0};
    tv[9]  = '{0, 1, 56, 0, 0, 3, 13, 0, 0};
    tv[10] = '{0, 0,  0, 0, 0, 3, 13, 0, 0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_wr", int'(wr0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_addr", int'(addr0), 0);
    chk("rst_wdata", int'(wdata0), 0);
    rst = 1'b0;

    run4("plain", 1'b0, -1);
    run4("bad21", 1'b0, 9);
    run4("gap", 1'b1, -1);

    // start pulsed mid-matrix, then reset after 5 accepts.
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int idx = 0; idx < 5; idx++) begin
      start4 = (idx == 2);
      valid4 = 1'b1;
      data4  = 16'((idx / 4) + (idx % 4) + 1);
      @(negedge clk);
    end
    start4 = 1'b0;
    valid4 = 1'b0;
    chk("mid_busy", int'(busy0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", int'(ready0), 0);
    chk("mid_rst_busy", int'(busy0), 0);
    chk("mid_rst_wr", int'(wr0), 0);
    chk("mid_rst_done", int'(done0), 0);
    chk("mid_rst_addr", int'(addr0), 0);
    chk("mid_rst_wdata", int'(wdata0), 0);
    chk("mid_rst_err", int'(err0), 0);
    check_writes("partial", 4);
    run4("fresh", 1'b0, -1);
    chk("done_count", ndone0, 4);

    for (int i = 0; i < 11; i++) begin
      start2 = tv[i].st;
      valid2 = tv[i].vl;
      data2  = 16'(tv[i].d);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), int'(ready2), tv[i].rdy);
      chk($sformatf("v%0d_wr", i), int'(wr2), tv[i].wr);
      chk($sformatf("v%0d_addr", i), int'(addr2), tv[i].a);
      chk($sformatf("v%0d_wdata", i), int'(wdata2), tv[i].wd);
      chk($sformatf("v%0d_busy", i), int'(busy2), tv[i].busy);
      chk($sformatf("v%0d_done", i), int'(done2), tv[i].done);
      chk($sformatf("v%0d_err", i), int'(err2), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
